pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and stall controller for the in-order pipeline CPU. It replaces the fixed two-level forwarding and load-use logic with a scoreboard that tracks destination registers across a configurable number of post-ID stages. From that scoreboard it generates forward selects for ID-stage (branch compare, JR) and EX-stage operands, and the PC, IF/ID, ID/EX and EX/MEM stall, flush and bubble controls. It also holds EX for multi-cycle operations.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_match.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The scoreboard stores register addresses at a fixed SB_AW width so the
// entry type can live in a package; narrower address buses are zero-extended.
package pipe_hazard_pkg;

  localparam int SB_AW = 8;

  // Earliest position at which a result can be forwarded.
  localparam logic [1:0] RDY_ALU  = 2'd2;
  localparam logic [1:0] RDY_LOAD = 2'd3;

  // Forward-select value meaning "take the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [1:0]       rdy;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, addr: '0, rdy: RDY_ALU};

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Scoreboard lookup for one operand: finds the youngest in-flight producer of
// addr_i at or beyond position MIN_POS, reports its position as the select and
// flags a hazard when the value will not be ready by the consumer's use point.
module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int AW      = 5,
  parameter int FW      = 2,
  parameter int MIN_POS = 1
) (
  input  sb_entry_t         sb_i [DEPTH],
  input  logic [AW-1:0]     addr_i,
  input  logic              use_pos_i,
  output logic              haz_o,
  output logic [FW-1:0]     sel_o
);

  logic found;

  // Scan from the youngest position; $0 never matches.
  always_comb begin
    found = 1'b0;
    haz_o = 1'b0;
    sel_o = FW'(FWD_RF);
    for (int i = MIN_POS - 1; i < DEPTH; i++) begin
      if (!found && sb_i[i].valid && (addr_i != '0) &&
          (sb_i[i].addr == SB_AW'(addr_i))) begin
        found = 1'b1;
        sel_o = FW'(i + 1);
        haz_o = (i + 1 + int'(use_pos_i)) < int'(sb_i[i].rdy);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order pipeline.
// Define HAZ_MC_EN to build the multi-cycle EX counter and the ex_hold path;
// without it id_mc/id_mc_cycles are ignored and ex_hold/exmem_bubble stay 0.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter  int DEPTH = 3,
  parameter  int AW    = 5,
  parameter  int CNT_W = 5,
  localparam int FW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_use_early,
  input  logic             id_wr_en,
  input  logic [AW-1:0]    id_wr_addr,
  input  logic             id_is_load,
  input  logic             id_redirect,
  input  logic             id_mc,
  input  logic [CNT_W-1:0] id_mc_cycles,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic             exmem_bubble,
  output logic [FW-1:0]    fwd_id_rs,
  output logic [FW-1:0]    fwd_id_rt,
  output logic [FW-1:0]    fwd_ex_a,
  output logic [FW-1:0]    fwd_ex_b
);

  sb_entry_t     sb_q [DEPTH];
  sb_entry_t     sb_d [DEPTH];
  sb_entry_t     id_entry;
  logic [AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [AW-1:0] id_rs_eff, id_rt_eff;
  logic          haz_rs, haz_rt, haz_ea, haz_eb;
  logic [FW-1:0] sel_rs, sel_rt, sel_ea, sel_eb;
  logic          stall, hold, advance;

  assign id_rs_eff = id_rs_used ? id_rs : '0;
  assign id_rt_eff = id_rt_used ? id_rt : '0;

  hazard_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW), .MIN_POS(1)) u_match_id_rs (
    .sb_i(sb_q), .addr_i(id_rs_eff), .use_pos_i(~id_use_early), .haz_o(haz_rs), .sel_o(sel_rs));
  hazard_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW), .MIN_POS(1)) u_match_id_rt (
    .sb_i(sb_q), .addr_i(id_rt_eff), .use_pos_i(~id_use_early), .haz_o(haz_rt), .sel_o(sel_rt));
  hazard_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW), .MIN_POS(2)) u_match_ex_a (
    .sb_i(sb_q), .addr_i(ex_rs_q), .use_pos_i(1'b0), .haz_o(haz_ea), .sel_o(sel_ea));
  hazard_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW), .MIN_POS(2)) u_match_ex_b (
    .sb_i(sb_q), .addr_i(ex_rt_q), .use_pos_i(1'b0), .haz_o(haz_eb), .sel_o(sel_eb));

  assign stall   = id_valid & (haz_rs | haz_rt);
  assign advance = id_valid & ~stall;

  assign id_entry = '{valid: advance & id_wr_en,
                      addr:  SB_AW'(id_wr_addr),
                      rdy:   id_is_load ? RDY_LOAD : RDY_ALU};

`ifdef HAZ_MC_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count down the extra EX cycles; load only when an mc op enters EX.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    else if (advance && id_mc) cnt_d = id_mc_cycles;
  end

  // Multi-cycle counter register; reset aborts any hold in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hold = (cnt_q != '0);
`else
  logic unused_mc;
  assign unused_mc = id_mc ^ (^id_mc_cycles);
  assign hold      = 1'b0;
`endif

  // Scoreboard shift: normal advance ages every entry; a hold pins EX and
  // lets the older stages drain with an empty slot behind EX.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) sb_d[i] = sb_q[i];
    if (hold) begin
      for (int i = DEPTH - 1; i >= 2; i--) sb_d[i] = sb_q[i - 1];
      sb_d[1] = SB_EMPTY;
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) sb_d[i] = sb_q[i - 1];
      sb_d[0] = id_entry;
    end
  end

  // EX operand addresses follow ID/EX: frozen on hold, cleared for a bubble.
  always_comb begin
    ex_rs_d = ex_rs_q;
    ex_rt_d = ex_rt_q;
    if (!hold) begin
      ex_rs_d = advance ? id_rs_eff : '0;
      ex_rt_d = advance ? id_rt_eff : '0;
    end
  end

  // Scoreboard and EX operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= SB_EMPTY;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      sb_q    <= sb_d;
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
    end
  end

  // Pipeline controls with priority hold > stall > redirect.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    if (hold) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ex_hold      = 1'b1;
      exmem_bubble = 1'b1;
    end else if (stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = id_redirect & id_valid;
    end
  end

  // ID forwarding only applies to operands consumed in ID and already ready.
  assign fwd_id_rs = (!id_use_early || haz_rs) ? FW'(FWD_RF) : sel_rs;
  assign fwd_id_rt = (!id_use_early || haz_rt) ? FW'(FWD_RF) : sel_rt;
  // A not-yet-ready producer is never a legal EX source; stalls keep this
  // case out of reach, so it only guards against selecting a stale stage.
  assign fwd_ex_a  = haz_ea ? FW'(FWD_RF) : sel_ea;
  assign fwd_ex_b  = haz_eb ? FW'(FWD_RF) : sel_eb;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model.
// Define HAZ_MC_EN to exercise the multi-cycle hold path.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int CNT_W = 5;
  localparam int FW    = $clog2(DEPTH + 1);
`ifdef HAZ_MC_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0, id_use_early = 1'b0;
  logic id_wr_en = 1'b0, id_is_load = 1'b0, id_redirect = 1'b0, id_mc = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_wr_addr = '0;
  logic [CNT_W-1:0] id_mc_cycles = '0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, exmem_bubble;
  logic [FW-1:0] fwd_id_rs, fwd_id_rt, fwd_ex_a, fwd_ex_b;

  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_use_early(id_use_early),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .id_redirect(id_redirect), .id_mc(id_mc), .id_mc_cycles(id_mc_cycles),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .ex_hold(ex_hold), .exmem_bubble(exmem_bubble), .fwd_id_rs(fwd_id_rs),
    .fwd_id_rt(fwd_id_rt), .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b));

  always #5 clk = ~clk;

  // ---------------- reference model: in-flight instructions by position ----
  bit m_v   [0:DEPTH];
  int m_dst [0:DEPTH];
  bit m_ld  [0:DEPTH];
  int m_ex_rs = 0, m_ex_rt = 0, m_cnt = 0;

  function automatic int youngest(input int a, input int from);
    for (int p = from; p <= DEPTH; p++)
      if (m_v[p] && m_dst[p] == a) return p;
    return 0;
  endfunction

  // Result of a producer at position p is usable once p has reached
  // 2 (ALU) or 3 (load); an EX consumer reaches there one position later.
  function automatic bit op_haz(input bit used, input int a, input bit early);
    int p;
    if (!used || a == 0) return 1'b0;
    p = youngest(a, 1);
    if (p == 0) return 1'b0;
    return (p + (early ? 0 : 1)) < (m_ld[p] ? 3 : 2);
  endfunction

  function automatic int op_fid(input bit used, input int a, input bit early);
    if (!early || !used || a == 0) return 0;
    if (op_haz(used, a, early)) return 0;
    return youngest(a, 1);
  endfunction

  function automatic bit st_f();
    return id_valid && (op_haz(id_rs_used, int'(id_rs), id_use_early) ||
                        op_haz(id_rt_used, int'(id_rt), id_use_early));
  endfunction

  function automatic bit hd_f();
    return MC_EN && (m_cnt != 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p <= DEPTH; p++) m_v[p] <= 1'b0;
      m_ex_rs <= 0;
      m_ex_rt <= 0;
      m_cnt   <= 0;
    end else begin
      if (hd_f()) begin
        for (int p = DEPTH; p >= 3; p--) begin
          m_v[p] <= m_v[p-1]; m_dst[p] <= m_dst[p-1]; m_ld[p] <= m_ld[p-1];
        end
        m_v[2] <= 1'b0;
      end else begin
        for (int p = DEPTH; p >= 2; p--) begin
          m_v[p] <= m_v[p-1]; m_dst[p] <= m_dst[p-1]; m_ld[p] <= m_ld[p-1];
        end
        m_v[1]   <= id_valid && !st_f() && id_wr_en;
        m_dst[1] <= int'(id_wr_addr);
        m_ld[1]  <= id_is_load;
        m_ex_rs  <= (id_valid && !st_f() && id_rs_used) ? int'(id_rs) : 0;
        m_ex_rt  <= (id_valid && !st_f() && id_rt_used) ? int'(id_rt) : 0;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (MC_EN && id_valid && !st_f() && id_mc) m_cnt <= int'(id_mc_cycles);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    chk("pc_we",        pc_we,        !(hd_f() || st_f()));
    chk("ifid_we",      ifid_we,      !(hd_f() || st_f()));
    chk("ifid_flush",   ifid_flush,   !hd_f() && !st_f() && id_redirect && id_valid);
    chk("idex_bubble",  idex_bubble,  !hd_f() && st_f());
    chk("ex_hold",      ex_hold,      hd_f());
    chk("exmem_bubble", exmem_bubble, hd_f());
    chk("fwd_id_rs", fwd_id_rs, op_fid(id_rs_used, int'(id_rs), id_use_early));
    chk("fwd_id_rt", fwd_id_rt, op_fid(id_rt_used, int'(id_rt), id_use_early));
    chk("fwd_ex_a",  fwd_ex_a,  (m_ex_rs != 0) ? youngest(m_ex_rs, 2) : 0);
    chk("fwd_ex_b",  fwd_ex_b,  (m_ex_rt != 0) ? youngest(m_ex_rt, 2) : 0);
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input bit early, input bit wr, input int wa, input bit ld, input bit redir);
    id_valid = v;  id_rs = AW'(rs); id_rs_used = rsu; id_rt = AW'(rt); id_rt_used = rtu;
    id_use_early = early; id_wr_en = wr; id_wr_addr = AW'(wa); id_is_load = ld;
    id_redirect = redir; id_mc = 1'b0; id_mc_cycles = '0;
  endtask

  task automatic nop_drain();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    // Reset values, during and right after reset.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_we", pc_we, 1);
    chk("rst_idex_bubble", idex_bubble, 0);
    chk("rst_fwd_ex_a", fwd_ex_a, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ifid_we", ifid_we, 1);
    chk("post_rst_ex_hold", ex_hold, 0);

    // ALU -> dependent EX use: no stall, both operands from position 2.
    step();
    id_set(1, 1, 1, 2, 1, 0, 1, 3, 0, 0);
    step();
    id_set(1, 3, 1, 3, 1, 0, 1, 4, 0, 0);
    #1;
    chk("alu_ex_no_stall", pc_we, 1);
    chk("alu_ex_no_bubble", idex_bubble, 0);
    step();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alu_fwd_ex_a", fwd_ex_a, 2);
    chk("alu_fwd_ex_b", fwd_ex_b, 2);
    nop_drain();

    // Load -> EX use: one stall cycle, then forward from position 3.
    id_set(1, 1, 1, 0, 0, 0, 1, 5, 1, 0);
    step();
    id_set(1, 5, 1, 1, 1, 0, 1, 6, 0, 0);
    #1;
    chk("ld_ex_stall_pc_we", pc_we, 0);
    chk("ld_ex_stall_bubble", idex_bubble, 1);
    step();
    #1;
    chk("ld_ex_release", pc_we, 1);
    step();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ld_fwd_ex_a", fwd_ex_a, 3);
    chk("ld_fwd_ex_b", fwd_ex_b, 0);
    nop_drain();

    // ALU -> branch in ID: one stall (redirect masked), then forward from 2.
    id_set(1, 1, 1, 2, 1, 0, 1, 7, 0, 0);
    step();
    id_set(1, 7, 1, 0, 1, 1, 0, 0, 0, 1);
    #1;
    chk("br_alu_stall", pc_we, 0);
    chk("br_alu_no_flush", ifid_flush, 0);
    chk("br_alu_fwd0", fwd_id_rs, 0);
    step();
    #1;
    chk("br_alu_release", pc_we, 1);
    chk("br_alu_fwd_id", fwd_id_rs, 2);
    chk("br_alu_flush", ifid_flush, 1);
    nop_drain();

    // Load -> branch in ID: two stalls, then forward from 3.
    id_set(1, 1, 1, 0, 0, 0, 1, 7, 1, 0);
    step();
    id_set(1, 7, 1, 0, 1, 1, 0, 0, 0, 1);
    #1;
    chk("br_ld_stall1", pc_we, 0);
    step();
    #1;
    chk("br_ld_stall2", pc_we, 0);
    chk("br_ld_stall2_flush", ifid_flush, 0);
    step();
    #1;
    chk("br_ld_release", pc_we, 1);
    chk("br_ld_fwd_id", fwd_id_rs, 3);
    nop_drain();

    // Load writing $0 never creates a dependency.
    id_set(1, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    step();
    id_set(1, 0, 1, 0, 1, 0, 1, 9, 0, 0);
    #1;
    chk("r0_no_stall", pc_we, 1);
    step();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r0_fwd_ex_a", fwd_ex_a, 0);
    chk("r0_fwd_ex_b", fwd_ex_b, 0);
    nop_drain();

    // Two in-flight writers of $8: the younger one wins.
    id_set(1, 1, 1, 2, 1, 0, 1, 8, 0, 0);
    step();
    id_set(1, 1, 1, 2, 1, 0, 1, 8, 0, 0);
    step();
    id_set(1, 8, 1, 2, 1, 0, 1, 10, 0, 0);
    #1;
    chk("two_wr_no_stall", pc_we, 1);
    step();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("two_wr_fwd_ex_a", fwd_ex_a, 2);
    nop_drain();

    // Invalid ID slot with a matching source does not stall.
    id_set(1, 1, 1, 0, 0, 0, 1, 13, 1, 0);
    step();
    id_set(0, 13, 1, 0, 0, 0, 1, 14, 0, 0);
    #1;
    chk("invalid_no_stall", pc_we, 1);
    nop_drain();

    // Multi-cycle op with 4 extra cycles.
    id_set(1, 1, 1, 2, 1, 0, 1, 11, 0, 0);
    id_mc = 1'b1;
    id_mc_cycles = CNT_W'(4);
    step();
    id_set(1, 1, 1, 2, 1, 0, 1, 12, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mc_hold", ex_hold, MC_EN);
      chk("mc_exmem_bubble", exmem_bubble, MC_EN);
      chk("mc_pc_we", pc_we, !MC_EN);
      step();
    end
    #1;
    chk("mc_hold_end", ex_hold, 0);
    chk("mc_end_pc_we", pc_we, 1);
    nop_drain();

    // Reset asserted during the second hold cycle aborts the hold at once.
    id_set(1, 1, 1, 2, 1, 0, 1, 11, 0, 0);
    id_mc = 1'b1;
    id_mc_cycles = CNT_W'(4);
    step();
    id_set(1, 1, 1, 2, 1, 0, 1, 12, 0, 0);
    #1;
    chk("mcr_hold_c1", ex_hold, MC_EN);
    step();
    #1;
    rst = 1'b1;
    #1;
    chk("mcr_rst_hold", ex_hold, 0);
    chk("mcr_rst_exmem", exmem_bubble, 0);
    chk("mcr_rst_pc_we", pc_we, 1);
    chk("mcr_rst_ifid_we", ifid_we, 1);
    chk("mcr_rst_bubble", idex_bubble, 0);
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("mcr_post_hold", ex_hold, 0);
    nop_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
